// File: rtl/tcp_option_serializer.sv
// TCP header-option generator: latches an option request on start, plans a
// layout of at most ten 32-bit words and streams it over valid/ready.
module tcp_option_serializer #(
  parameter int WORD_W   = 32,
  parameter int MAX_SACK = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [8:0]            option_av,
  input  logic [15:0]           mss,
  input  logic [7:0]            scale_wnd,
  input  logic [2:0]            sack_nbr,
  input  logic [64*MAX_SACK-1:0] sack_blk,
  input  logic [63:0]           time_stp,
  output logic [WORD_W-1:0]     opt_data,
  output logic                  opt_valid,
  input  logic                  opt_ready,
  output logic                  opt_last,
  output logic [3:0]            opt_words,
  output logic                  sack_trunc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [4:0] {
    ST_IDLE, ST_PLAN, ST_MSS, ST_WS, ST_SP, ST_TS0, ST_TS1, ST_TS2, ST_SK_H,
    ST_SK0, ST_SK1, ST_SK2, ST_SK3, ST_SK4, ST_SK5, ST_SK6, ST_SK7, ST_EOL, ST_FIN
  } state_t;

  localparam logic [2:0]  MAX_SACK_C = 3'(MAX_SACK);
  localparam logic [31:0] NOP_WORD   = 32'h01010101;

  state_t             st_r;
  logic               mss_en_r, ws_en_r, sp_en_r, ts_en_r, eol_en_r;
  logic [2:0]         n_r;
  logic [15:0]        mss_r;
  logic [7:0]         shift_r;
  logic [63:0]        ts_r;
  logic [31:0]        sk_w_r [0:7];
  logic [WORD_W-1:0]  opt_data_r;
  logic               opt_valid_r, opt_last_r, sack_trunc_r, busy_r, done_r;
  logic [3:0]         opt_words_r;

  logic [3:0]         base_s, rem_s, half_s, sk_words_s, left_s, words_s;
  logic [2:0]         req_s, fit_s, n_s;
  logic               eol_s, trunc_s, unused_av_s;
  logic [255:0]       blk_pad_s;
  state_t             adv_s, step_s;
  logic [WORD_W-1:0]  beat_s;
  logic               last_s;

  assign unused_av_s = ^{option_av[7:6], option_av[1]};
  assign blk_pad_s   = 256'(sack_blk);

  function automatic logic in_plan(input state_t s);
    case (s)
      ST_MSS:                    in_plan = mss_en_r;
      ST_WS:                     in_plan = ws_en_r;
      ST_SP:                     in_plan = sp_en_r;
      ST_TS0, ST_TS1, ST_TS2:    in_plan = ts_en_r;
      ST_SK_H, ST_SK0, ST_SK1:   in_plan = (n_r >= 3'd1);
      ST_SK2, ST_SK3:            in_plan = (n_r >= 3'd2);
      ST_SK4, ST_SK5:            in_plan = (n_r >= 3'd3);
      ST_SK6, ST_SK7:            in_plan = (n_r >= 3'd4);
      ST_EOL:                    in_plan = eol_en_r;
      ST_FIN:                    in_plan = 1'b1;
      default:                   in_plan = 1'b0;
    endcase
  endfunction

  // First planned state strictly after s in emission order; FIN terminates.
  function automatic state_t next_of(input state_t s);
    state_t nxt;
    nxt = ST_FIN;
    for (int i = 17; i >= 2; i--) begin
      nxt = (i > int'(s) && in_plan(state_t'(i[4:0]))) ? state_t'(i[4:0]) : nxt;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] word_of(input state_t s);
    case (s)
      ST_MSS:  word_of = {8'h02, 8'h04, mss_r};
      ST_WS:   word_of = {8'h01, 8'h03, 8'h03, shift_r};
      ST_SP:   word_of = 32'h01010402;
      ST_TS0:  word_of = 32'h0101080A;
      ST_TS1:  word_of = ts_r[63:32];
      ST_TS2:  word_of = ts_r[31:0];
      ST_SK_H: word_of = {8'h01, 8'h01, 8'h05, ({2'b00, n_r, 3'b000} + 8'd2)};
      ST_SK0:  word_of = sk_w_r[0];
      ST_SK1:  word_of = sk_w_r[1];
      ST_SK2:  word_of = sk_w_r[2];
      ST_SK3:  word_of = sk_w_r[3];
      ST_SK4:  word_of = sk_w_r[4];
      ST_SK5:  word_of = sk_w_r[5];
      ST_SK6:  word_of = sk_w_r[6];
      ST_SK7:  word_of = sk_w_r[7];
      default: word_of = 32'h00000000;
    endcase
  endfunction

  // Layout plan computed from the raw request so it can be registered on start.
  always_comb begin
    base_s = {3'b000, option_av[2]} + {3'b000, option_av[3]} + {3'b000, option_av[4]}
           + (option_av[8] ? 4'd3 : 4'd0);
    rem_s  = 4'd10 - base_s;
    if (option_av[5]) begin
      req_s = (sack_nbr < MAX_SACK_C) ? sack_nbr : MAX_SACK_C;
    end else begin
      req_s = 3'd0;
    end
    half_s     = (rem_s - 4'd1) >> 1;
    fit_s      = half_s[2:0];
    n_s        = (req_s < fit_s) ? req_s : fit_s;
    sk_words_s = (n_s == 3'd0) ? 4'd0 : ({n_s, 1'b0} + 4'd1);
    left_s     = rem_s - sk_words_s;
    eol_s      = option_av[0] & (left_s != 4'd0);
    words_s    = base_s + sk_words_s + {3'b000, eol_s};
    trunc_s    = (n_s < req_s) | (option_av[0] & (left_s == 4'd0));
  end

  // st_r names the word at the head of the beat currently on the bus.
  generate
    if (WORD_W == 64) begin : g_w64
      state_t sec_s;
      assign sec_s  = next_of(adv_s);
      assign beat_s = {word_of(adv_s), (sec_s == ST_FIN) ? NOP_WORD : word_of(sec_s)};
      assign last_s = (sec_s == ST_FIN) || (next_of(sec_s) == ST_FIN);
      assign step_s = next_of(next_of(st_r));
    end else begin : g_w32
      assign beat_s = word_of(adv_s);
      assign last_s = (next_of(adv_s) == ST_FIN);
      assign step_s = next_of(st_r);
    end
  endgenerate

  assign adv_s = (st_r == ST_PLAN) ? next_of(ST_PLAN) : step_s;

  // Job FSM: latch request, then stream beats; FIN also accepts a new start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_r         <= ST_IDLE;
      mss_en_r     <= 1'b0;
      ws_en_r      <= 1'b0;
      sp_en_r      <= 1'b0;
      ts_en_r      <= 1'b0;
      eol_en_r     <= 1'b0;
      n_r          <= 3'd0;
      mss_r        <= 16'h0000;
      shift_r      <= 8'h00;
      ts_r         <= 64'h0;
      for (int i = 0; i < 8; i++) sk_w_r[i] <= 32'h00000000;
      opt_data_r   <= {WORD_W{1'b0}};
      opt_valid_r  <= 1'b0;
      opt_last_r   <= 1'b0;
      opt_words_r  <= 4'd0;
      sack_trunc_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (st_r)
        ST_IDLE, ST_FIN: begin
          done_r <= 1'b0;
          if (start) begin
            mss_en_r     <= option_av[2];
            ws_en_r      <= option_av[3];
            sp_en_r      <= option_av[4];
            ts_en_r      <= option_av[8];
            eol_en_r     <= eol_s;
            n_r          <= n_s;
            mss_r        <= mss;
            shift_r      <= scale_wnd;
            ts_r         <= time_stp;
            for (int i = 0; i < 4; i++) begin
              sk_w_r[2*i]   <= blk_pad_s[64*i+32 +: 32];
              sk_w_r[2*i+1] <= blk_pad_s[64*i +: 32];
            end
            opt_words_r  <= words_s;
            sack_trunc_r <= trunc_s;
            busy_r       <= 1'b1;
            st_r         <= ST_PLAN;
          end else begin
            st_r <= ST_IDLE;
          end
        end
        ST_PLAN: begin
          if (adv_s == ST_FIN) begin
            st_r   <= ST_FIN;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            st_r        <= adv_s;
            opt_data_r  <= beat_s;
            opt_last_r  <= last_s;
            opt_valid_r <= 1'b1;
          end
        end
        default: begin
          if (opt_ready) begin
            if (opt_last_r) begin
              st_r        <= ST_FIN;
              opt_data_r  <= {WORD_W{1'b0}};
              opt_valid_r <= 1'b0;
              opt_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              st_r       <= adv_s;
              opt_data_r <= beat_s;
              opt_last_r <= last_s;
            end
          end else begin
            st_r <= st_r;
          end
        end
      endcase
    end
  end

  assign opt_data   = opt_data_r;
  assign opt_valid  = opt_valid_r;
  assign opt_last   = opt_last_r;
  assign opt_words  = opt_words_r;
  assign sack_trunc = sack_trunc_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_tcp_option_serializer.sv
// Scoreboard bench: 32- and 64-bit instances share stimulus; a list-based
// reference model supplies expected beats, monitors pop and compare.
module tb_tcp_option_serializer;

  localparam int          MAX_SACK = 4;
  localparam logic [31:0] NOP      = 32'h01010101;

  logic         clk = 1'b0;
  logic         reset_n, start, opt_ready;
  logic [8:0]   option_av;
  logic [15:0]  mss;
  logic [7:0]   scale_wnd;
  logic [2:0]   sack_nbr;
  logic [255:0] sack_blk;
  logic [63:0]  time_stp;

  logic [31:0]  data32;
  logic         valid32, last32, trunc32, busy32, done32;
  logic [3:0]   words32;
  logic [63:0]  data64;
  logic         valid64, last64, trunc64, busy64, done64;
  logic [3:0]   words64;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       q32[$];
  beat_t       q64[$];
  logic [31:0] exp_w[$];
  logic        exp_trunc;
  int          errors = 0;
  int          checks = 0;
  int          hs32 = 0;
  int          hs64 = 0;

  always #5 clk = ~clk;

  tcp_option_serializer #(.WORD_W(32), .MAX_SACK(MAX_SACK)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .option_av(option_av), .mss(mss),
    .scale_wnd(scale_wnd), .sack_nbr(sack_nbr), .sack_blk(sack_blk), .time_stp(time_stp),
    .opt_data(data32), .opt_valid(valid32), .opt_ready(opt_ready), .opt_last(last32),
    .opt_words(words32), .sack_trunc(trunc32), .busy(busy32), .done(done32));

  tcp_option_serializer #(.WORD_W(64), .MAX_SACK(MAX_SACK)) dut64 (
    .clk(clk), .reset_n(reset_n), .start(start), .option_av(option_av), .mss(mss),
    .scale_wnd(scale_wnd), .sack_nbr(sack_nbr), .sack_blk(sack_blk), .time_stp(time_stp),
    .opt_data(data64), .opt_valid(valid64), .opt_ready(opt_ready), .opt_last(last64),
    .opt_words(words64), .sack_trunc(trunc64), .busy(busy64), .done(done64));

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: list of option words in emission order, then split into beats.
  task automatic build_model();
    int    rem, req, n, sz;
    beat_t b;
    exp_w.delete();
    if (option_av[2]) exp_w.push_back({8'h02, 8'h04, mss});
    if (option_av[3]) exp_w.push_back({8'h01, 8'h03, 8'h03, scale_wnd});
    if (option_av[4]) exp_w.push_back(32'h01010402);
    if (option_av[8]) begin
      exp_w.push_back(32'h0101080A);
      exp_w.push_back(time_stp[63:32]);
      exp_w.push_back(time_stp[31:0]);
    end
    rem = 10 - exp_w.size();
    req = 0;
    if (option_av[5]) req = (int'(sack_nbr) < MAX_SACK) ? int'(sack_nbr) : MAX_SACK;
    n = (rem >= 1) ? (rem - 1) / 2 : 0;
    if (n > req) n = req;
    if (n > 0) begin
      exp_w.push_back({8'h01, 8'h01, 8'h05, 8'(2 + 8 * n)});
      for (int i = 0; i < n; i++) begin
        exp_w.push_back(sack_blk[64*i+32 +: 32]);
        exp_w.push_back(sack_blk[64*i +: 32]);
      end
    end
    rem = 10 - exp_w.size();
    exp_trunc = (n < req) || (option_av[0] && rem == 0);
    if (option_av[0] && rem >= 1) exp_w.push_back(32'h00000000);
    sz = exp_w.size();
    for (int i = 0; i < sz; i++) begin
      b.data = {32'h0, exp_w[i]};
      b.last = (i == sz - 1);
      q32.push_back(b);
    end
    for (int i = 0; i < sz; i += 2) begin
      b.data = {exp_w[i], (i + 1 < sz) ? exp_w[i+1] : NOP};
      b.last = (i + 2 >= sz);
      q64.push_back(b);
    end
  endtask

  logic [32:0] held32;
  bit          hold32 = 1'b0;
  beat_t       bm32;
  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      hold32 = 1'b0;
    end else begin
      if (hold32) begin
        check("stall_valid32", 96'(valid32), 96'd1);
        if (valid32) check("stall_data32", 96'({data32, last32}), 96'(held32));
      end
      if (valid32 && opt_ready) begin
        if (q32.size() == 0) begin
          check("extra_beat32", 96'({data32, last32}), 96'd0);
        end else begin
          bm32 = q32.pop_front();
          check("beat32", 96'({data32, last32}), 96'({bm32.data[31:0], bm32.last}));
        end
        hs32++;
        hold32 = 1'b0;
      end else if (valid32) begin
        hold32 = 1'b1;
        held32 = {data32, last32};
      end else begin
        hold32 = 1'b0;
      end
    end
  end

  logic [64:0] held64;
  bit          hold64 = 1'b0;
  beat_t       bm64;
  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      hold64 = 1'b0;
    end else begin
      if (hold64) begin
        check("stall_valid64", 96'(valid64), 96'd1);
        if (valid64) check("stall_data64", 96'({data64, last64}), 96'(held64));
      end
      if (valid64 && opt_ready) begin
        if (q64.size() == 0) begin
          check("extra_beat64", 96'({data64, last64}), 96'd0);
        end else begin
          bm64 = q64.pop_front();
          check("beat64", 96'({data64, last64}), 96'({bm64.data, bm64.last}));
        end
        hs64++;
        hold64 = 1'b0;
      end else if (valid64) begin
        hold64 = 1'b1;
        held64 = {data64, last64};
      end else begin
        hold64 = 1'b0;
      end
    end
  end

  task automatic randomize_fields();
    mss       = 16'($urandom);
    scale_wnd = 8'($urandom);
    time_stp  = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) sack_blk[32*i +: 32] = $urandom;
  endtask

  // mode 0: ready held high, timing checked; 1: 3-cycle stall on beat 2 plus
  // an ignored start; 2: random ready and inputs scrambled after start.
  task automatic run_job(input logic [8:0] av, input logic [2:0] nbr, input int mode);
    int k, d32k, d64k, nb32, nb64, e32, e64;
    @(negedge clk);
    option_av = av;
    sack_nbr  = nbr;
    opt_ready = 1'b1;
    build_model();
    nb32 = q32.size();
    nb64 = q64.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy32", 96'(busy32), 96'd1);
    check("busy64", 96'(busy64), 96'd1);
    check("words32", 96'(words32), 96'(exp_w.size()));
    check("words64", 96'(words64), 96'(exp_w.size()));
    check("trunc32", 96'(trunc32), 96'(exp_trunc));
    check("trunc64", 96'(trunc64), 96'(exp_trunc));
    if (mode == 2) begin
      randomize_fields();
      option_av = 9'($urandom);
      sack_nbr  = 3'($urandom);
    end
    k = 1;
    d32k = -1;
    d64k = -1;
    while (k < 300 && (d32k < 0 || d64k < 0)) begin
      if (done32 && d32k < 0) d32k = k;
      if (done64 && d64k < 0) d64k = k;
      case (mode)
        1: begin
          opt_ready = !(k >= 3 && k <= 5);
          start     = (k == 4);
          if (k == 4) option_av = 9'h000;
        end
        2:       opt_ready = 1'($urandom_range(0, 1));
        default: opt_ready = 1'b1;
      endcase
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_seen32", 96'(d32k >= 0), 96'd1);
    check("done_seen64", 96'(d64k >= 0), 96'd1);
    if (mode != 2) begin
      e32 = 2 + nb32 + ((mode == 1 && nb32 >= 2) ? 3 : 0);
      e64 = 2 + nb64 + ((mode == 1 && nb64 >= 2) ? 3 : 0);
      check("done_cycle32", 96'(d32k), 96'(e32));
      check("done_cycle64", 96'(d64k), 96'(e64));
    end
    check("drained32", 96'(q32.size()), 96'd0);
    check("drained64", 96'(q64.size()), 96'd0);
    check("idle32", 96'({busy32, valid32}), 96'd0);
    check("idle64", 96'({busy64, valid64}), 96'd0);
    q32.delete();
    q64.delete();
  endtask

  task automatic run_reset_job();
    int k;
    @(negedge clk);
    option_av = 9'h13D;
    sack_nbr  = 3'd3;
    opt_ready = 1'b1;
    build_model();
    hs32  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (hs32 < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reset_reach", 96'(hs32 >= 3), 96'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid32", 96'({data32, valid32, last32, words32, trunc32, busy32, done32}), 96'd0);
    check("rst_mid64", 96'({data64, valid64, last64, words64, trunc64, busy64, done64}), 96'd0);
    q32.delete();
    q64.delete();
    @(negedge clk);
    check("rst_nodone", 96'({done32, done64}), 96'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    opt_ready = 1'b0;
    option_av = 9'h000;
    sack_nbr  = 3'd0;
    mss       = 16'h0000;
    scale_wnd = 8'h00;
    sack_blk  = 256'h0;
    time_stp  = 64'h0;
    #12;
    check("reset32", 96'({data32, valid32, last32, words32, trunc32, busy32, done32}), 96'd0);
    check("reset64", 96'({data64, valid64, last64, words64, trunc64, busy64, done64}), 96'd0);
    @(negedge clk);
    reset_n = 1'b1;

    mss       = 16'h05B4;
    scale_wnd = 8'd7;
    time_stp  = 64'h11223344_55667788;
    for (int i = 0; i < 8; i++) sack_blk[32*i +: 32] = 32'hA0000000 + 32'(i);
    run_job(9'h01C, 3'd0, 0);
    run_job(9'h13D, 3'd3, 0);
    run_job(9'h020, 3'd4, 0);
    run_job(9'h00C, 3'd0, 0);
    run_job(9'h004, 3'd0, 0);
    run_job(9'h020, 3'd0, 0);
    run_job(9'h13D, 3'd3, 1);
    run_reset_job();
    run_job(9'h13D, 3'd3, 0);
    run_job(9'h000, 3'd0, 0);

    for (int it = 0; it < 60; it++) begin
      randomize_fields();
      run_job(9'($urandom), 3'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0) ? 0 : 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
